// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg -- shared constants for the seven-segment scan driver.
//   SEG_W      : segment bus width
//   seg_bit_e  : segment order, led = {a,b,c,d,e,f,g}, g is bit 0
//   SEG_BLANK  : all segments off (active-low)
//   SEG_LUT    : 16-entry active-low hex decode, indexed by nibble
package seven_seg_pkg;

  localparam int SEG_W = 7;

  typedef enum int {
    SEG_G = 0,
    SEG_F = 1,
    SEG_E = 2,
    SEG_D = 3,
    SEG_C = 4,
    SEG_B = 5,
    SEG_A = 6
  } seg_bit_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Entry k is the pattern for nibble k; listed F down to 0.
  localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if -- load/data request and display outputs.
//   load    : single-cycle capture request
//   data    : NUM_DIGITS hex nibbles, nibble 0 = rightmost digit
//   pending : captured data waiting for the next frame boundary
//   an      : active-low digit enables
//   led     : active-low segments {a,b,c,d,e,f,g}
// Modports: master (data source / bench), slave (driver).
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  import seven_seg_pkg::*;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] data;
  logic                    pending;
  logic [NUM_DIGITS-1:0]   an;
  logic [SEG_W-1:0]        led;

  modport master (output load, data, input pending, an, led);
  modport slave  (input load, data, output pending, an, led);
endinterface

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder -- combinational hex to active-low segment decode.
//   nib : 4-bit hex value
//   seg : segments {a,b,c,d,e,f,g}, active-low
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);
  assign seg = SEG_LUT[nib];
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver -- multiplexed seven-segment display driver with
// frame-synchronous (tear-free) data update.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : seven_seg_scan_driver_if.slave (load, data, pending, an, led)
// Each digit is lit for REFRESH_CYCLES clocks; new data is held in a
// pending register and only becomes active at a frame boundary (digit
// index wrapping to 0). an/led are registered from the current index and
// active data, so they trail that state by one clock.
// Optional build macro SEVEN_SEG_LZ_BLANK_EN: blank leading zero digits
// (digit 0 always shown).
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  seven_seg_scan_driver_if.slave bus
);
  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]            cnt;
  logic [IDX_W-1:0]            idx;
  logic [NUM_DIGITS-1:0][3:0]  active_q;
  logic [NUM_DIGITS-1:0][3:0]  pend_q;
  logic                        pending_q;
  logic                        wrap;
  logic                        frame_end;
  logic [3:0]                  nib;
  logic [SEG_W-1:0]            seg;
  logic [SEG_W-1:0]            led_d;
  logic [SEG_W-1:0]            led_q;
  logic [NUM_DIGITS-1:0]       an_d;
  logic [NUM_DIGITS-1:0]       an_q;

  assign wrap      = (cnt == CNT_LAST);
  // With a single digit IDX_LAST is 0, so every wrap is a frame boundary.
  assign frame_end = wrap && (idx == IDX_LAST);

  // Refresh counter and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pending/active data. A load on the boundary cycle bypasses the pending
  // register so the new value appears in the very next frame; any older
  // pending value is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q  <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else if (bus.load && frame_end) begin
      active_q  <= bus.data;
      pending_q <= 1'b0;
    end else if (bus.load) begin
      pend_q    <= bus.data;
      pending_q <= 1'b1;
    end else if (frame_end && pending_q) begin
      active_q  <= pend_q;
      pending_q <= 1'b0;
    end
  end

  assign nib = active_q[idx];

  seven_seg_decoder u_dec (
    .nib (nib),
    .seg (seg)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // Highest digit holding a nonzero nibble; digits above it are blanked.
  // Starts at 0 so digit 0 is never blank.
  logic [IDX_W-1:0] msd;
  always_comb begin
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++)
      if (active_q[k] != 4'h0) msd = IDX_W'(k);
  end
  assign led_d = (idx > msd) ? SEG_BLANK : seg;
`else
  assign led_d = seg;
`endif

  always_comb begin
    an_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (idx == IDX_W'(k)) an_d[k] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= '1;
      led_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      led_q <= led_d;
    end
  end

  assign bus.an      = an_q;
  assign bus.led     = led_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver -- directed bench, NUM_DIGITS=4, REFRESH_CYCLES=4.
// ncyc counts rising edges since reset release; outputs sampled on the
// falling edge after edge ncyc reflect digit ((ncyc-1)/4)%4. Frame
// boundaries are edges 16, 32, 48, ...
module tb_seven_seg_scan_driver;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;

  seven_seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_an(int n);
    int d;
    d = ((n - 1) / 4) % 4;
    return ~(4'b0001 << d);
  endfunction

  task automatic step();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic run_to(int n);
    while (ncyc < n) step();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b exp 1111", bus.an); end
    checks++; if (bus.led !== 7'b1111111) begin errors++; $display("FAIL reset_led got %b exp 1111111", bus.led); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", bus.pending); end
    reset = 1'b0;
    ncyc  = 0;
  endtask

  task automatic test_scan();
    logic [6:0] el;
    for (int n = 1; n <= 16; n++) begin
      step();
      el = 7'b0000001;
`ifdef SEVEN_SEG_LZ_BLANK_EN
      if (((ncyc - 1) / 4) % 4 != 0) el = 7'b1111111;
`endif
      checks++; if (bus.an !== exp_an(ncyc)) begin errors++; $display("FAIL scan_an cyc %0d got %b exp %b", ncyc, bus.an, exp_an(ncyc)); end
      checks++; if (bus.led !== el) begin errors++; $display("FAIL scan_led cyc %0d got %b exp %b", ncyc, bus.led, el); end
    end
  endtask

  task automatic test_load_midframe();
    logic [6:0] exp4 [4];
    exp4 = '{7'b0000000, 7'b0100000, 7'b0010010, 7'b1001100};
    run_to(20);
    bus.data = 16'h4268; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL mid_pending_set got %b exp 1", bus.pending); end
    while (ncyc < 32) begin
      step();
      checks++; if (bus.led !== 7'b0000001) begin errors++; $display("FAIL mid_no_tear cyc %0d got %b exp 0000001", ncyc, bus.led); end
      checks++; if (bus.pending !== (ncyc < 32)) begin errors++; $display("FAIL mid_pending cyc %0d got %b exp %b", ncyc, bus.pending, ncyc < 32); end
    end
    for (int d = 0; d < 4; d++) begin
      run_to(33 + 4 * d);
      checks++; if (bus.led !== exp4[d]) begin errors++; $display("FAIL mid_digit%0d got %b exp %b", d, bus.led, exp4[d]); end
      checks++; if (bus.an !== exp_an(ncyc)) begin errors++; $display("FAIL mid_an%0d got %b exp %b", d, bus.an, exp_an(ncyc)); end
    end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL mid_pending_clr got %b exp 0", bus.pending); end
  endtask

  task automatic test_overwrite();
    run_to(45);
    bus.data = 16'h1111; bus.load = 1'b1;
    step();
    bus.data = 16'h000F;
    step();
    bus.load = 1'b0;
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL ovw_pending got %b exp 1", bus.pending); end
    step();  // edge 48: boundary, display still shows old digit 3
    checks++; if (bus.led !== 7'b1001100) begin errors++; $display("FAIL ovw_old_d3 got %b exp 1001100", bus.led); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL ovw_pending_clr got %b exp 0", bus.pending); end
    step();
    checks++; if (bus.led !== 7'b0111000) begin errors++; $display("FAIL ovw_digit0 got %b exp 0111000", bus.led); end
  endtask

  task automatic test_load_on_boundary();
    run_to(63);
    bus.data = 16'h0001; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL bnd_pending got %b exp 0", bus.pending); end
    step();
    checks++; if (bus.led !== 7'b1001111) begin errors++; $display("FAIL bnd_digit0 got %b exp 1001111", bus.led); end
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL bnd_an got %b exp 1110", bus.an); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL bnd_pending2 got %b exp 0", bus.pending); end
  endtask

  task automatic test_reset_pending();
    bus.data = 16'h1234; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL rstp_pending_set got %b exp 1", bus.pending); end
    step();
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL rstp_an got %b exp 1111", bus.an); end
    checks++; if (bus.led !== 7'b1111111) begin errors++; $display("FAIL rstp_led got %b exp 1111111", bus.led); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL rstp_pending got %b exp 0", bus.pending); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ncyc  = 0;
    step();
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL rstp_first_an got %b exp 1110", bus.an); end
    checks++; if (bus.led !== 7'b0000001) begin errors++; $display("FAIL rstp_first_led got %b exp 0000001", bus.led); end
    checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL rstp_pending2 got %b exp 0", bus.pending); end
    run_to(17);
    checks++; if (bus.led !== 7'b0000001) begin errors++; $display("FAIL rstp_no_xfer got %b exp 0000001", bus.led); end
    checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL rstp_an17 got %b exp 1110", bus.an); end
  endtask

`ifdef SEVEN_SEG_LZ_BLANK_EN
  task automatic test_lz_blank();
    logic [6:0] exp4 [4];
    exp4 = '{7'b0000001, 7'b0010010, 7'b1111111, 7'b1111111};
    run_to(31);
    bus.data = 16'h0020; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int d = 0; d < 4; d++) begin
      run_to(33 + 4 * d);
      checks++; if (bus.led !== exp4[d]) begin errors++; $display("FAIL lz_digit%0d got %b exp %b", d, bus.led, exp4[d]); end
    end
    run_to(47);
    bus.data = 16'h0000; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    run_to(49);
    checks++; if (bus.led !== 7'b0000001) begin errors++; $display("FAIL lz_zero_d0 got %b exp 0000001", bus.led); end
    run_to(53);
    checks++; if (bus.led !== 7'b1111111) begin errors++; $display("FAIL lz_zero_d1 got %b exp 1111111", bus.led); end
  endtask
`endif

  initial begin
    reset    = 1'b0;
    bus.load = 1'b0;
    bus.data = '0;
    #1 reset = 1'b1;
    test_reset();
    test_scan();
    test_load_midframe();
    test_overwrite();
    test_load_on_boundary();
    test_reset_pending();
`ifdef SEVEN_SEG_LZ_BLANK_EN
    test_lz_blank();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
